seq_detector_moore_param: RTL and testbench

- Parametrised Moore-type serial pattern detector; successor to the fixed-pattern 3-bit detectors in the sequential FSM library.
- Pattern length and value set by parameter; overlapping or non-overlapping detection selected at run time.
- Adds an input-enable qualifier, a saturating match counter and a debug state output.
- Used as a generic framing and sync-word detector on single-bit serial streams.

---
 rtl/seq_detector_moore_param.sv | 85 ++++++++
 tb/tb_seq_detector_moore_param.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_detector_moore_param.sv
// Parametrised Moore serial pattern detector with KMP-style transitions,
// run-time overlap select, input enable and a saturating match counter.
module seq_detector_moore_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter int             CNT_W   = 8,
    parameter int             SW      = $clog2(N+1)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic [SW-1:0]    Q
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [SW-1:0]    S_FULL  = SW'(N);

    // The state value is the matched prefix length, so it is a plain count
    // rather than a symbolic enumeration.
    typedef logic [SW-1:0] state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_next;

    // Longest prefix of PATTERN that is a suffix of (PATTERN prefix of length s, then b).
    // Called with s = N this gives the overlapping continuation after a full match.
    function automatic state_t kmp_next(input int s, input logic b);
        logic [16:0] w;
        int          len;
        int          best;
        logic        ok;
        w = '0;
        for (int i = 0; i < N; i++) begin
            if (i < s) w[i] = PATTERN[N-1-i];
        end
        w[s] = b;
        len  = s + 1;
        best = 0;
        for (int k = 1; k <= N; k++) begin
            if (k <= len) begin
                ok = 1'b1;
                for (int j = 0; j < N; j++) begin
                    if (j < k && w[len-k+j] != PATTERN[N-1-j]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return SW'(best);
    endfunction

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= '0;
            match_cnt <= '0;
        end else begin
            state     <= state_next;
            match_cnt <= cnt_next;
        end
    end

    // Non-overlapping mode restarts from the empty prefix after a full match.
    always_comb begin
        state_next = state;
        cnt_next   = match_cnt;
        if (en) begin
            for (int s = 0; s <= N; s++) begin
                if (state == SW'(s)) begin
                    if (s == N && !overlap) state_next = kmp_next(0, x);
                    else                    state_next = kmp_next(s, x);
                end
            end
            if (state_next == S_FULL && match_cnt != CNT_MAX)
                cnt_next = match_cnt + 1'b1;
        end
    end

    assign z = (state == S_FULL);
    assign Q = state;

endmodule

// File: tb/tb_seq_detector_moore_param.sv
// Self-checking bench: directed vector table, hand-written saturation run and
// randomized traffic against a history-based reference model.
module tb_seq_detector_moore_param;

    localparam int A_N  = 4;
    localparam int A_CW = 8;
    localparam int A_SW = 3;
    localparam int B_N  = 3;
    localparam int B_CW = 2;
    localparam int B_SW = 2;
    localparam logic [15:0] A_PAT = 16'b1011;
    localparam logic [15:0] B_PAT = 16'b111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            a_clear = 1'b1, a_en = 1'b0, a_x = 1'b0, a_ov = 1'b0;
    logic            a_z;
    logic [A_CW-1:0] a_cnt;
    logic [A_SW-1:0] a_q;
    logic            b_clear = 1'b1, b_en = 1'b0, b_x = 1'b0, b_ov = 1'b0;
    logic            b_z;
    logic [B_CW-1:0] b_cnt;
    logic [B_SW-1:0] b_q;

    seq_detector_moore_param #(.N(A_N), .PATTERN(4'b1011), .CNT_W(A_CW)) dut_a (
        .clk(clk), .clear(a_clear), .en(a_en), .x(a_x), .overlap(a_ov),
        .z(a_z), .match_cnt(a_cnt), .Q(a_q)
    );

    seq_detector_moore_param #(.N(B_N), .PATTERN(3'b111), .CNT_W(B_CW)) dut_b (
        .clk(clk), .clear(b_clear), .en(b_en), .x(b_x), .overlap(b_ov),
        .z(b_z), .match_cnt(b_cnt), .Q(b_q)
    );

    typedef struct {
        logic clr, en, x, ov;
        int   q, z, cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic add(input logic clr, en, x, ov, input int q, z, cnt);
        vec_t v;
        v = '{clr, en, x, ov, q, z, cnt};
        vecs.push_back(v);
    endtask

    task automatic check_output(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic ac, ae, ax, ao, input logic bc, be, bx, bo);
        @(negedge clk);
        a_clear = ac; a_en = ae; a_x = ax; a_ov = ao;
        b_clear = bc; b_en = be; b_x = bx; b_ov = bo;
        @(posedge clk);
        #1;
    endtask

    // Reference: keep the recent input history; the state is the longest
    // suffix of that history equal to a prefix of the pattern.
    task automatic model_step(input logic clr, en, xb, ov, input logic [15:0] pat,
                              input int n, input int cmax,
                              inout logic [15:0] hist, inout int hlen,
                              inout int st, inout int cnt);
        logic ok;
        if (clr) begin
            hist = '0; hlen = 0; st = 0; cnt = 0;
        end else if (en) begin
            if (st == n && !ov) begin
                hist = '0; hlen = 0;
            end
            hist = {hist[14:0], xb};
            if (hlen < 16) hlen++;
            st = 0;
            for (int k = 1; k <= n; k++) begin
                if (k <= hlen) begin
                    ok = 1'b1;
                    for (int j = 0; j < k; j++)
                        if (hist[k-1-j] != pat[n-1-j]) ok = 1'b0;
                    if (ok) st = k;
                end
            end
            if (st == n && cnt < cmax) cnt++;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] ha, hb;
        int la, lb, sa, sb, ca, cb;
        logic rc, re, rx, ro, qc, qe, qx, qo;

        // reset with en=1 and arbitrary x
        add(1,1,1,1, 0,0,0); add(1,1,0,1, 0,0,0);
        // overlapping 1011011
        add(0,1,1,1, 1,0,0); add(0,1,0,1, 2,0,0); add(0,1,1,1, 3,0,0); add(0,1,1,1, 4,1,1);
        add(0,1,0,1, 2,0,1); add(0,1,1,1, 3,0,1); add(0,1,1,1, 4,1,2);
        add(1,0,0,0, 0,0,0);
        // non-overlapping 1011011
        add(0,1,1,0, 1,0,0); add(0,1,0,0, 2,0,0); add(0,1,1,0, 3,0,0); add(0,1,1,0, 4,1,1);
        add(0,1,0,0, 0,0,1); add(0,1,1,0, 1,0,1); add(0,1,1,0, 1,0,1);
        add(1,0,0,0, 0,0,0);
        // enable gating, then hold with z high, then non-overlap restart
        add(0,1,1,1, 1,0,0); add(0,1,0,1, 2,0,0); add(0,1,1,1, 3,0,0);
        add(0,0,0,1, 3,0,0); add(0,0,1,1, 3,0,0); add(0,0,0,1, 3,0,0);
        add(0,1,1,1, 4,1,1); add(0,0,0,0, 4,1,1); add(0,0,1,1, 4,1,1);
        add(0,1,1,0, 1,0,1);
        add(1,0,0,0, 0,0,0);
        // mid-match clear wins over en
        add(0,1,1,1, 1,0,0); add(0,1,0,1, 2,0,0); add(0,1,1,1, 3,0,0);
        add(1,1,1,1, 0,0,0); add(0,1,1,1, 1,0,0); add(0,1,0,1, 2,0,0);
        add(1,0,0,0, 0,0,0);
        // overlap from full match on x=1 falls back to prefix "1"
        add(0,1,1,1, 1,0,0); add(0,1,0,1, 2,0,0); add(0,1,1,1, 3,0,0); add(0,1,1,1, 4,1,1);
        add(0,1,1,1, 1,0,1);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].clr, vecs[i].en, vecs[i].x, vecs[i].ov, 1'b1, 1'b0, 1'b0, 1'b0);
            check_output($sformatf("vec%0d Q", i),   int'(a_q),   vecs[i].q);
            check_output($sformatf("vec%0d z", i),   int'(a_z),   vecs[i].z);
            check_output($sformatf("vec%0d cnt", i), int'(a_cnt), vecs[i].cnt);
        end

        // N=3, 111, 2-bit counter: consecutive matches and saturation
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            check_output($sformatf("sat%0d Q", i),   int'(b_q),   (i < 3) ? i : 3);
            check_output($sformatf("sat%0d z", i),   int'(b_z),   (i >= 3) ? 1 : 0);
            check_output($sformatf("sat%0d cnt", i), int'(b_cnt), (i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2));
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_output("sat_nonovl Q",   int'(b_q),   1);
        check_output("sat_nonovl z",   int'(b_z),   0);
        check_output("sat_nonovl cnt", int'(b_cnt), 3);

        // randomized traffic on both instances
        ha = '0; hb = '0; la = 0; lb = 0; sa = 0; sb = 0; ca = 0; cb = 0;
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            rc = ($urandom_range(0, 39) == 0);
            re = ($urandom_range(0, 3) != 0);
            rx = $urandom_range(0, 1);
            ro = $urandom_range(0, 1);
            qc = ($urandom_range(0, 59) == 0);
            qe = ($urandom_range(0, 3) != 0);
            qx = ($urandom_range(0, 3) != 0);
            qo = $urandom_range(0, 1);
            model_step(rc, re, rx, ro, A_PAT, A_N, 255, ha, la, sa, ca);
            model_step(qc, qe, qx, qo, B_PAT, B_N, 3,   hb, lb, sb, cb);
            apply_stimulus(rc, re, rx, ro, qc, qe, qx, qo);
            check_output($sformatf("rndA%0d Q", i),   int'(a_q),   sa);
            check_output($sformatf("rndA%0d z", i),   int'(a_z),   (sa == A_N) ? 1 : 0);
            check_output($sformatf("rndA%0d cnt", i), int'(a_cnt), ca);
            check_output($sformatf("rndB%0d Q", i),   int'(b_q),   sb);
            check_output($sformatf("rndB%0d z", i),   int'(b_z),   (sb == B_N) ? 1 : 0);
            check_output($sformatf("rndB%0d cnt", i), int'(b_cnt), cb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
